// File: rtl/acc_dcache_port_arbiter_if.sv
// Requester, dcache-port and status signals of the dcache port arbiter.
// slave is the arbiter's view; master is the surrounding requesters/cache.
interface acc_dcache_port_arbiter_if #(
  parameter int NrReq          = 2,
  parameter int MaxOutstanding = 7,
  parameter int AddrWidth      = 64,
  parameter int DataWidth      = 64
);
  localparam int CntWidth = $clog2(MaxOutstanding + 1);

  logic                         flush;
  logic [NrReq-1:0]             req_valid;
  logic [NrReq-1:0]             req_ready;
  logic [NrReq*AddrWidth-1:0]   req_addr;
  logic [NrReq-1:0]             req_we;
  logic [NrReq*DataWidth-1:0]   req_wdata;
  logic [NrReq*DataWidth/8-1:0] req_be;
  logic                         mem_req_valid;
  logic                         mem_req_ready;
  logic [AddrWidth-1:0]         mem_addr;
  logic                         mem_we;
  logic [DataWidth-1:0]         mem_wdata;
  logic [DataWidth/8-1:0]       mem_be;
  logic                         mem_rsp_valid;
  logic [DataWidth-1:0]         mem_rsp_rdata;
  logic [NrReq-1:0]             rsp_valid;
  logic [DataWidth-1:0]         rsp_rdata;
  logic [CntWidth-1:0]          outstanding;
  logic                         busy;
  logic                         spurious_rsp;

  modport slave (
    input  flush, req_valid, req_addr, req_we, req_wdata, req_be,
           mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output req_ready, mem_req_valid, mem_addr, mem_we, mem_wdata, mem_be,
           rsp_valid, rsp_rdata, outstanding, busy, spurious_rsp
  );

  modport master (
    output flush, req_valid, req_addr, req_we, req_wdata, req_be,
           mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  req_ready, mem_req_valid, mem_addr, mem_we, mem_wdata, mem_be,
           rsp_valid, rsp_rdata, outstanding, busy, spurious_rsp
  );
endinterface

// File: rtl/acc_dcache_port_arbiter.sv
// Round-robin share of one dcache port, credit-capped, with in-order response routing.
// Request and response paths are 0-cycle combinational; a stalled grant is held until accepted.
module acc_dcache_port_arbiter #(
  parameter int NrReq          = 2,
  parameter int MaxOutstanding = 7,
  parameter int AddrWidth      = 64,
  parameter int DataWidth      = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  acc_dcache_port_arbiter_if.slave bus
);
  localparam int IdWidth  = $clog2(NrReq);
  localparam int CntWidth = $clog2(MaxOutstanding + 1);
  localparam int PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int BeWidth  = DataWidth / 8;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 we;
    logic [DataWidth-1:0] wdata;
    logic [BeWidth-1:0]   be;
  } mem_req_t;

  logic [IdWidth-1:0]  rr_q;
  logic                lock_q;
  logic [IdWidth-1:0]  lock_idx_q;
  logic [CntWidth-1:0] cnt_q;
  logic [PtrWidth-1:0] wr_ptr_q;
  logic [PtrWidth-1:0] rd_ptr_q;
  logic [IdWidth-1:0]  id_fifo_q [MaxOutstanding];

  logic [IdWidth-1:0]  sel;
  logic [IdWidth-1:0]  cand;
  logic                found;
  logic                grant_en;
  logic                accept;
  logic                pop;
  mem_req_t            sel_req;
  mem_req_t            mem_req;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits are taken from the registered count only, so a same-cycle response never frees a slot.
  assign grant_en = rst_ni && !bus.flush && (cnt_q < CntWidth'(MaxOutstanding));

  always_comb begin
    found = 1'b0;
    sel   = lock_idx_q;
    cand  = '0;
    if (lock_q) begin
      found = 1'b1;
    end else begin
      for (int i = 0; i < NrReq; i++) begin
        cand = IdWidth'((int'(rr_q) + i) % NrReq);
        if (!found && bus.req_valid[cand]) begin
          found = 1'b1;
          sel   = cand;
        end
      end
    end
  end

  always_comb begin
    sel_req.addr  = bus.req_addr[sel*AddrWidth +: AddrWidth];
    sel_req.we    = bus.req_we[sel];
    sel_req.wdata = bus.req_wdata[sel*DataWidth +: DataWidth];
    sel_req.be    = bus.req_be[sel*BeWidth +: BeWidth];
  end

  assign bus.mem_req_valid = grant_en && found;
  assign mem_req           = bus.mem_req_valid ? sel_req : '0;
  assign bus.mem_addr      = mem_req.addr;
  assign bus.mem_we        = mem_req.we;
  assign bus.mem_wdata     = mem_req.wdata;
  assign bus.mem_be        = mem_req.be;

  assign accept        = bus.mem_req_valid && bus.mem_req_ready;
  assign bus.req_ready = accept ? (NrReq'(1) << sel) : '0;

  // The ID FIFO occupancy always equals cnt_q, so the count doubles as the empty flag.
  assign pop              = rst_ni && bus.mem_rsp_valid && (cnt_q != '0);
  assign bus.rsp_valid    = pop ? (NrReq'(1) << id_fifo_q[rd_ptr_q]) : '0;
  assign bus.rsp_rdata    = bus.mem_rsp_rdata;
  assign bus.spurious_rsp = rst_ni && bus.mem_rsp_valid && (cnt_q == '0);
  assign bus.outstanding  = cnt_q;
  assign bus.busy         = (cnt_q != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      if (accept) begin
        rr_q     <= (sel == IdWidth'(NrReq - 1)) ? '0 : sel + 1'b1;
        wr_ptr_q <= ptr_inc(wr_ptr_q);
        lock_q   <= 1'b0;
      end else if (bus.mem_req_valid) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel;
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({accept, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      id_fifo_q[wr_ptr_q] <= sel;
    end
  end
endmodule

// File: tb/tb_acc_dcache_port_arbiter.sv
// Randomized and directed bench: request path checked against a queue-based model,
// responses checked by a decoupled scoreboard monitor.
module tb_acc_dcache_port_arbiter;
  localparam int N    = 2;
  localparam int MAXO = 7;
  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int BW   = DW / 8;
  localparam int QSZ  = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  acc_dcache_port_arbiter_if #(.NrReq(N), .MaxOutstanding(MAXO), .AddrWidth(AW), .DataWidth(DW)) bus ();

  acc_dcache_port_arbiter #(.NrReq(N), .MaxOutstanding(MAXO), .AddrWidth(AW), .DataWidth(DW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  logic [N-1:0]  v;
  logic [N-1:0]  we;
  logic [AW-1:0] addr  [N];
  logic [DW-1:0] wdata [N];
  logic [BW-1:0] be    [N];
  logic          flush, mready, rspv;
  logic [DW-1:0] rdata;

  assign bus.req_valid     = v;
  assign bus.req_we        = we;
  assign bus.flush         = flush;
  assign bus.mem_req_ready = mready;
  assign bus.mem_rsp_valid = rspv;
  assign bus.mem_rsp_rdata = rdata;
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign bus.req_addr[g*AW +: AW]  = addr[g];
    assign bus.req_wdata[g*DW +: DW] = wdata[g];
    assign bus.req_be[g*BW +: BW]    = be[g];
  end

  int n_checks, n_errors;
  int m_cnt, m_rr, m_lock_idx, mem_pend;
  bit m_lock;
  int exp_src [QSZ];
  int wr_idx, rd_idx;
  logic [N-1:0] keep;
  logic [N-1:0] last_ready;
  bit last_mv, last_spur, last_busy;
  int last_out;
  logic [N-1:0] gseq [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic new_req(input int i);
    addr[i]  = {$urandom, $urandom};
    wdata[i] = {$urandom, $urandom};
    be[i]    = BW'($urandom);
    we[i]    = 1'($urandom_range(0, 1));
    v[i]     = 1'b1;
  endtask

  // One clock cycle: entered at posedge+1 with inputs applied, returns at the next posedge+1.
  task automatic step();
    int sel, dec;
    bit found, mv, acc;
    logic [N-1:0] exp_rdy;
    sel   = 0;
    found = 1'b0;
    if (m_lock) begin
      sel   = m_lock_idx;
      found = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (!found && v[j]) begin
          sel   = j;
          found = 1'b1;
        end
      end
    end
    mv      = !flush && (m_cnt < MAXO) && found;
    acc     = mv && mready;
    exp_rdy = acc ? (N'(1) << sel) : '0;

    @(negedge clk);
    last_ready = bus.req_ready;
    last_mv    = bus.mem_req_valid;
    last_spur  = bus.spurious_rsp;
    last_busy  = bus.busy;
    last_out   = int'(bus.outstanding);
    chk("mem_req_valid", 64'(bus.mem_req_valid), 64'(mv));
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    if (mv) begin
      chk("mem_addr", bus.mem_addr, addr[sel]);
      chk("mem_we", 64'(bus.mem_we), 64'(we[sel]));
      chk("mem_wdata", bus.mem_wdata, wdata[sel]);
      chk("mem_be", 64'(bus.mem_be), 64'(be[sel]));
    end else begin
      chk("mem_addr_idle", bus.mem_addr, 64'(0));
    end
    chk("outstanding", 64'(bus.outstanding), 64'(m_cnt));
    chk("busy", 64'(bus.busy), 64'(m_cnt != 0));
    chk("spurious", 64'(bus.spurious_rsp), 64'(rspv && m_cnt == 0));

    @(posedge clk);
    dec = (rspv && m_cnt > 0) ? 1 : 0;
    if (rspv && mem_pend > 0) mem_pend--;
    if (acc) begin
      exp_src[wr_idx % QSZ] = sel;
      wr_idx++;
      m_rr   = (sel + 1) % N;
      m_lock = 1'b0;
      mem_pend++;
    end else if (mv) begin
      m_lock     = 1'b1;
      m_lock_idx = sel;
    end
    m_cnt = m_cnt + (acc ? 1 : 0) - dec;
    #1;
    if (acc) begin
      if (keep[sel]) new_req(sel);
      else v[sel] = 1'b0;
    end
    rdata = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    v      = '1;
    rspv   = 1'b1;
    mready = 1'b1;
    #1;
    chk("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'(0));
    chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_outstanding", 64'(bus.outstanding), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_spurious", 64'(bus.spurious_rsp), 64'(0));
    chk("rst_mem_addr", bus.mem_addr, 64'(0));
    chk("rst_mem_wdata", bus.mem_wdata, 64'(0));
    v      = '0;
    rspv   = 1'b0;
    keep   = '0;
    m_cnt  = 0;
    m_rr   = 0;
    m_lock = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int guard;
    guard  = 0;
    keep   = '0;
    mready = 1'b1;
    flush  = 1'b0;
    while ((v != '0 || mem_pend > 0) && guard < 300) begin
      rspv = (mem_pend > 0);
      step();
      guard++;
    end
    chk("drain_pending", 64'(mem_pend), 64'(0));
    rspv = 1'b0;
  endtask

  // Scoreboard monitor: classifies every response the DUT presents and pops the expected source.
  initial begin
    bit empty;
    rd_idx = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_idx = wr_idx;
      end else if (bus.rsp_valid != '0 || bus.spurious_rsp || rspv) begin
        empty = (rd_idx == wr_idx);
        chk("rsp_kind", 64'({bus.rsp_valid != '0, bus.spurious_rsp}),
            64'(!rspv ? 2'b00 : (empty ? 2'b01 : 2'b10)));
        if (bus.rsp_valid != '0 && !empty) begin
          chk("rsp_route", 64'(bus.rsp_valid), 64'(N'(1) << exp_src[rd_idx % QSZ]));
          chk("rsp_rdata", bus.rsp_rdata, rdata);
          rd_idx++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0; n_errors = 0; wr_idx = 0;
    m_cnt = 0; m_rr = 0; m_lock = 1'b0; m_lock_idx = 0; mem_pend = 0;
    v = '0; we = '0; keep = '0; flush = 1'b0; mready = 1'b0; rspv = 1'b0; rdata = '0;
    for (int i = 0; i < N; i++) begin
      addr[i] = '0; wdata[i] = '0; be[i] = '0;
    end
    do_reset();

    // Both requesters streaming, one response per cycle one cycle after acceptance.
    keep = '1; mready = 1'b1;
    new_req(0); new_req(1);
    for (int c = 0; c < 8; c++) begin
      rspv = (mem_pend > 0);
      step();
      if (last_ready != '0) gseq.push_back(last_ready);
    end
    chk("t1_grant_count", 64'(gseq.size() >= 4), 64'(1));
    if (gseq.size() >= 4) begin
      chk("t1_grant0", 64'(gseq[0]), 64'(2'b01));
      chk("t1_grant1", 64'(gseq[1]), 64'(2'b10));
      chk("t1_grant2", 64'(gseq[2]), 64'(2'b01));
      chk("t1_grant3", 64'(gseq[3]), 64'(2'b10));
    end
    chk("t1_outstanding", 64'(last_out), 64'(1));
    drain();

    // Stalled grant on requester 1 holds while requester 0 arrives.
    new_req(1); mready = 1'b0;
    repeat (3) step();
    new_req(0);
    step();
    chk("t2_stall_valid", 64'(last_mv), 64'(1));
    chk("t2_stall_ready", 64'(last_ready), 64'(0));
    mready = 1'b1;
    step();
    chk("t2_grant_r1", 64'(last_ready), 64'(2'b10));
    step();
    chk("t2_grant_r0", 64'(last_ready), 64'(2'b01));
    drain();

    // Credit exhaustion and no same-cycle credit bypass.
    keep = 2'b01; new_req(0); mready = 1'b1; rspv = 1'b0;
    repeat (8) step();
    chk("t3_outstanding7", 64'(last_out), 64'(7));
    chk("t3_eighth_blocked", 64'(last_mv), 64'(0));
    rspv = 1'b1;
    step();
    chk("t3_no_bypass", 64'(last_mv), 64'(0));
    rspv = 1'b0; keep = '0;
    step();
    chk("t3_credit_back", 64'(last_ready), 64'(2'b01));

    // Simultaneous accept and response at a count of 3.
    rspv = 1'b1;
    repeat (4) step();
    new_req(1); rspv = 1'b1;
    step();
    chk("t4_cnt_before", 64'(last_out), 64'(3));
    chk("t4_accept", 64'(last_ready), 64'(2'b10));
    rspv = 1'b0;
    step();
    chk("t4_cnt_after", 64'(last_out), 64'(3));
    drain();

    // Flush while locked keeps the lock.
    new_req(1); mready = 1'b1;
    step();
    new_req(1); mready = 1'b0;
    step();
    new_req(0); flush = 1'b1;
    step();
    chk("t5_flush_lock_valid", 64'(last_mv), 64'(0));
    flush = 1'b0; mready = 1'b1;
    step();
    chk("t5_lock_resume", 64'(last_ready), 64'(2'b10));
    drain();

    // Flush with 4 in flight: no grants, responses still routed.
    keep = '1; new_req(0); new_req(1); mready = 1'b1; rspv = 1'b0;
    repeat (4) step();
    chk("t5_inflight4", 64'(m_cnt), 64'(4));
    flush = 1'b1; rspv = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t5_flush_no_grant", 64'(last_mv), 64'(0));
    end
    rspv = 1'b0;
    step();
    chk("t5_busy_clear", 64'(last_busy), 64'(0));
    drain();

    // Response with nothing in flight.
    rspv = 1'b1;
    step();
    chk("t6_spurious_pulse", 64'(last_spur), 64'(1));
    chk("t6_outstanding", 64'(last_out), 64'(0));
    rspv = 1'b0;
    step();
    chk("t6_spurious_single", 64'(last_spur), 64'(0));
    chk("t6_outstanding_after", 64'(last_out), 64'(0));

    // Randomized traffic.
    keep = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1) new_req(i);
      end
      flush  = ($urandom_range(0, 7) == 0);
      mready = ($urandom_range(0, 3) != 0);
      rspv   = (mem_pend > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
      step();
    end
    drain();

    // Reset with 5 in flight; late responses become spurious.
    keep = '1; new_req(0); new_req(1); mready = 1'b1; rspv = 1'b0;
    repeat (5) step();
    chk("t8_inflight5", 64'(last_out), 64'(4));
    do_reset();
    step();
    chk("t8_outstanding_after", 64'(last_out), 64'(0));
    drain();
    chk("scoreboard_empty", 64'(rd_idx), 64'(wr_idx));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
